// File: rtl/qsys_led_seq_if.sv
// Avalon-MM bundle for the LED sequencer: CPU-facing slave plus PIO-facing master.
// The slave modport is the sequencer's view; master is the bus/CPU side.
interface qsys_led_seq_if;
  logic [1:0]  s_address;
  logic        s_chipselect;
  logic        s_write_n;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  modport slave (
    input  s_address,
    input  s_chipselect,
    input  s_write_n,
    input  s_writedata,
    output s_readdata,
    output m_address,
    output m_write,
    output m_writedata,
    input  m_waitrequest
  );

  modport master (
    output s_address,
    output s_chipselect,
    output s_write_n,
    output s_writedata,
    input  s_readdata,
    input  m_address,
    input  m_write,
    input  m_writedata,
    output m_waitrequest
  );
endinterface

// File: rtl/qsys_led_seq.sv
// Autonomous LED pattern sequencer driving the LED PIO over Avalon-MM.
// Define QSYS_LED_SEQ_BOUNCE_EN to enable bounce mode (MODE 11).
module qsys_led_seq #(
  parameter int LED_W        = 10,
  parameter int DIV_W        = 26,
  parameter int RESET_PERIOD = 49_999_999
) (
  input  logic              clk,
  input  logic              reset_n,
  qsys_led_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    WRITE
  } state_e;

  localparam logic [DIV_W-1:0] PER_RST = DIV_W'(RESET_PERIOD);

  state_e           state_q;
  logic [2:0]       ctrl_q;
  logic [LED_W-1:0] pattern_q;
  logic [DIV_W-1:0] period_q;
  logic [LED_W-1:0] cur_q;
  logic [DIV_W-1:0] pre_q;
  logic             load_pend_q;
  logic             m_write_q;

  logic             wr_en;
  logic             ctrl_wr;
  logic             pat_wr;
  logic             per_wr;
  logic             run_rise;
  logic             do_load;
  logic             do_step;
  logic [LED_W-1:0] step_cur;
  logic [31:0]      rdata;

`ifdef QSYS_LED_SEQ_BOUNCE_EN
  logic             dir_q;
  logic             step_dir;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus.s_writedata[31:DIV_W];

  assign wr_en    = bus.s_chipselect && !bus.s_write_n;
  assign ctrl_wr  = wr_en && (bus.s_address == 2'd0);
  assign pat_wr   = wr_en && (bus.s_address == 2'd1);
  assign per_wr   = wr_en && (bus.s_address == 2'd2);
  assign run_rise = ctrl_wr && bus.s_writedata[0] && !ctrl_q[0];

  // Reload wins over a tick; in WRITE it only fires in the gap after a completion
  assign do_load = load_pend_q &&
                   ((state_q == IDLE) ||
                    (state_q == WAIT_TICK && ctrl_q[0]) ||
                    (state_q == WRITE && !m_write_q));
  assign do_step = (state_q == WAIT_TICK) && ctrl_q[0] &&
                   !load_pend_q && (pre_q == period_q);

  always_comb begin
    step_cur = cur_q;
`ifdef QSYS_LED_SEQ_BOUNCE_EN
    step_dir = dir_q;
`endif
    case (ctrl_q[2:1])
      2'b01: step_cur = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
      2'b10: step_cur = {cur_q[0], cur_q[LED_W-1:1]};
`ifdef QSYS_LED_SEQ_BOUNCE_EN
      2'b11: begin
        if (!dir_q) begin
          if (cur_q[LED_W-1]) begin
            step_dir = 1'b1;
            step_cur = cur_q >> 1;
          end else begin
            step_cur = cur_q << 1;
          end
        end else begin
          if (cur_q[0]) begin
            step_dir = 1'b0;
            step_cur = cur_q << 1;
          end else begin
            step_cur = cur_q >> 1;
          end
        end
      end
`endif
      default: step_cur = cur_q;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (bus.s_address)
      2'd0: rdata[2:0]       = ctrl_q;
      2'd1: rdata[LED_W-1:0] = pattern_q;
      2'd2: rdata[DIV_W-1:0] = period_q;
      2'd3: begin
        rdata[0]            = (state_q == WRITE);
        rdata[LED_W+15:16]  = cur_q;
      end
    endcase
  end

  assign bus.s_readdata  = rdata;
  assign bus.m_address   = 2'b00;
  assign bus.m_write     = m_write_q;
  assign bus.m_writedata = {{(32-LED_W){1'b0}}, cur_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      pattern_q   <= '0;
      period_q    <= PER_RST;
      cur_q       <= '0;
      pre_q       <= '0;
      load_pend_q <= 1'b0;
      m_write_q   <= 1'b0;
`ifdef QSYS_LED_SEQ_BOUNCE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      if (ctrl_wr) ctrl_q <= bus.s_writedata[2:0];
      if (pat_wr) pattern_q <= bus.s_writedata[LED_W-1:0];
      if (per_wr) period_q <= bus.s_writedata[DIV_W-1:0];

      if (do_load) begin
        cur_q <= pattern_q;
      end else if (do_step) begin
        cur_q <= step_cur;
      end
`ifdef QSYS_LED_SEQ_BOUNCE_EN
      if (do_load) begin
        dir_q <= 1'b0;
      end else if (do_step) begin
        dir_q <= step_dir;
      end
`endif

      // A new request arriving on the consuming edge must survive
      if (pat_wr || run_rise) begin
        load_pend_q <= 1'b1;
      end else if (do_load) begin
        load_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (do_load) begin
            state_q   <= WRITE;
            m_write_q <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (!ctrl_q[0]) begin
            state_q <= IDLE;
          end else if (do_load || do_step) begin
            state_q   <= WRITE;
            m_write_q <= 1'b1;
            pre_q     <= '0;
          end else begin
            pre_q <= pre_q + DIV_W'(1);
          end
        end
        WRITE: begin
          if (!m_write_q) begin
            if (do_load) begin
              m_write_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (!bus.m_waitrequest) begin
            m_write_q <= 1'b0;
            if (load_pend_q) begin
              state_q <= WRITE;
            end else if (ctrl_q[0]) begin
              state_q <= WAIT_TICK;
              pre_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          m_write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_led_seq.sv
// Scoreboard bench for qsys_led_seq: expected PIO writes are queued as
// stimulus is applied and matched against completed master transfers.
module tb_qsys_led_seq;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   cyc_cnt;

  logic [31:0] exp_q[$];
  logic        gap_en;
  logic        last_ok;
  int          last_t;
  logic        pv_w;
  logic [31:0] pv_d;
  logic [31:0] rv;

  qsys_led_seq_if bus ();

  qsys_led_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.s_address    = a;
    bus.s_writedata  = d;
    bus.s_chipselect = 1'b1;
    bus.s_write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.s_chipselect = 1'b0;
    bus.s_write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.s_address = a;
    #1;
    v = bus.s_readdata;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Completion monitor: hold-stability during stalls, data and spacing
  always @(negedge clk) begin
    if (!reset_n) begin
      pv_w = 1'b0;
    end else begin
      if (pv_w) begin
        chk("hold_w", {31'd0, bus.m_write}, 32'd1);
        chk("hold_d", bus.m_writedata, pv_d);
      end
      pv_w = bus.m_write && bus.m_waitrequest;
      pv_d = bus.m_writedata;
      if (bus.m_write && !bus.m_waitrequest) begin
        chk("m_addr", {30'd0, bus.m_address}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("q_empty", exp_q.size(), 1);
        end else begin
          chk("wdata", bus.m_writedata, exp_q.pop_front());
        end
        if (gap_en) begin
          if (last_ok) chk("gap", cyc_cnt - last_t, 5);
          last_t  = cyc_cnt;
          last_ok = 1'b1;
        end
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    gap_en  = 1'b0;
    last_ok = 1'b0;
    last_t  = 0;
    pv_w    = 1'b0;
    pv_d    = '0;
    reset_n = 1'b0;
    bus.s_address     = '0;
    bus.s_chipselect  = 1'b0;
    bus.s_write_n     = 1'b1;
    bus.s_writedata   = '0;
    bus.m_waitrequest = 1'b0;
    cyc(3);
    reset_n = 1'b1;

    // Reset state
    cyc(20);
    chk("rst_mw", {31'd0, bus.m_write}, 32'd0);
    chk("rst_md", bus.m_writedata, 32'd0);
    chk("rst_ma", {30'd0, bus.m_address}, 32'd0);
    rd(2'd0, rv); chk("rst_r0", rv, 32'd0);
    rd(2'd1, rv); chk("rst_r1", rv, 32'd0);
    rd(2'd2, rv); chk("rst_r2", rv, 32'd49_999_999);
    rd(2'd3, rv); chk("rst_r3", rv, 32'd0);

    // Rotate-left, PERIOD=3
    wr(2'd2, 32'd3);
    rd(2'd2, rv); chk("per_rb", rv, 32'd3);
    exp_q.push_back(32'h001);
    wr(2'd1, 32'h001);
    drain(100);
    gap_en  = 1'b1;
    last_ok = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h1 << i);
    exp_q.push_back(32'h001);
    wr(2'd0, 32'h3);
    drain(200);
    gap_en = 1'b0;
    wr(2'd0, 32'h0);

    // Rotate-right wrap
    wr(2'd0, 32'h4);
    exp_q.push_back(32'h001);
    wr(2'd1, 32'h001);
    drain(100);
    exp_q.push_back(32'h001);
    exp_q.push_back(32'h200);
    wr(2'd0, 32'h5);
    drain(100);
    wr(2'd0, 32'h0);
    rd(2'd0, rv); chk("ctrl_rb", rv, 32'h0);

    // Bounce (or static when bounce is compiled out)
    exp_q.push_back(32'h100);
    wr(2'd1, 32'h100);
    drain(100);
`ifdef QSYS_LED_SEQ_BOUNCE_EN
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h080);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100);
`endif
    wr(2'd0, 32'h7);
    rd(2'd0, rv); chk("mode3_rb", rv, 32'h7);
    drain(100);
    wr(2'd0, 32'h0);

    // Stall with PATTERN rewrite mid-transfer
    bus.m_waitrequest = 1'b1;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h155);
    wr(2'd0, 32'h3);
    cyc(2);
    rd(2'd3, rv); chk("busy_st", rv, 32'h0100_0001);
    wr(2'd1, 32'h155);
    cyc(1);
    bus.m_waitrequest = 1'b0;
    drain(100);
    wr(2'd0, 32'h0);

    // RUN cleared mid-transfer, then reset during a later transfer
    bus.m_waitrequest = 1'b1;
    exp_q.push_back(32'h155);
    wr(2'd0, 32'h3);
    cyc(2);
    wr(2'd0, 32'h0);
    cyc(1);
    bus.m_waitrequest = 1'b0;
    drain(100);
    rd(2'd3, rv); chk("idle_st", rv, 32'h0155_0000);
    bus.m_waitrequest = 1'b1;
    wr(2'd0, 32'h3);
    cyc(2);
    chk("pre_rst_w", {31'd0, bus.m_write}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst2_mw", {31'd0, bus.m_write}, 32'd0);
    chk("rst2_md", bus.m_writedata, 32'd0);
    cyc(2);
    reset_n = 1'b1;
    bus.m_waitrequest = 1'b0;
    rd(2'd0, rv); chk("rst2_r0", rv, 32'd0);
    rd(2'd1, rv); chk("rst2_r1", rv, 32'd0);
    rd(2'd2, rv); chk("rst2_r2", rv, 32'd49_999_999);
    rd(2'd3, rv); chk("rst2_r3", rv, 32'd0);
    cyc(10);
    chk("rst2_idle", {31'd0, bus.m_write}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
